hazard_ctrl: RTL
================

# hazard_ctrl

Central hazard, forwarding and stall sequencer for the 5-stage RV32I pipeline. It drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding muxes. It also sequences multi-cycle data-memory accesses through a ready handshake, with a timeout watchdog. Two hazard-event counters are kept for performance analysis.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum consecutive data-memory wait cycles before the error state is entered (range 2..1024).
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs1D`, `rs2D` in 5 each: source registers in ID.
- `rs1E`, `rs2E`, `rdE` in 5 each: source and destination registers in EX.
- `memReadE` in 1: the EX instruction is a load.
- `pcSrcE` in 1: taken branch, jal or jalr resolved in EX.
- `rdM` in 5, `regWriteM` in 1: MEM-stage destination register and its write enable.
- `rdW` in 5, `regWriteW` in 1: WB-stage destination register and its write enable.
- `dmemReqM` in 1: the MEM instruction accesses data memory.
- `dmemReadyM` in 1: data memory completes the access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM` out 1 each: hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- `flushD`, `flushE`, `flushW` out 1 each: bubble into the IF/ID, ID/EX and MEM/WB registers.
- `forwardAE`, `forwardBE` out 2 each: operand source select for EX.
- `memTimeout` out 1: sticky error flag.
- `stallCount` out CNT_W: number of cycles in which any stall output was high.
- `redirectCount` out CNT_W: number of accepted control redirects.

## Operation
- **Forwarding (combinational):**
  - Select `FWD_MEM` (2'b10) when `regWriteM`, `rdM`≠0 and `rdM`==`rs1E`.
  - Otherwise select `FWD_WB` (2'b01) when `regWriteW`, `rdW`≠0 and `rdW`==`rs1E`.
  - Otherwise select `FWD_RF` (2'b00).
  - `forwardBE` uses the same rule with `rs2E`. MEM takes priority over WB.
- **Signal definitions:**
  - memStall = `dmemReqM` & !`dmemReadyM`, or state==ERR.
  - loadUse = `memReadE` & `rdE`≠0 & (`rdE`==`rs1D` | `rdE`==`rs2D`).
- **Priority 1, memStall:**
  - `stallF`, `stallD`, `stallE`, `stallM` = 1 and `flushW` = 1.
  - All other flushes = 0.
  - A pending `pcSrcE` or loadUse is held, because EX is frozen. It is serviced in the first cycle after the stall releases.
- **Priority 2, `pcSrcE` (redirect):**
  - `flushD` = 1 and `flushE` = 1; no stalls.
  - Redirect wins over loadUse, because the dependent ID instruction is squashed.
  - `redirectCount` increments.
- **Priority 3, loadUse:**
  - `stallF` = 1, `stallD` = 1, `flushE` = 1.
  - The bubble lasts exactly one cycle.
- **Otherwise:** all stall and flush outputs are 0.
- **FSM (registered), states `RUN`, `WAIT`, `ERR`:**
  - `RUN` to `WAIT`: on `dmemReqM` & !`dmemReadyM`; the wait counter loads 1.
  - `WAIT` to `RUN`: on `dmemReadyM`; the wait counter clears.
  - `WAIT` to `ERR`: when the wait counter == `TIMEOUT`-1 and `dmemReadyM` is low. `memTimeout` is set.
  - `WAIT`, other cycles: the wait counter increments.
  - `ERR` is absorbing: the pipeline stays fully stalled with `flushW` = 1 until reset.
  - `dmemReadyM` in the same cycle as the request means no stall and no `WAIT` entry.
- **Counters:** `CNT_W` bits and wrap modulo 2^`CNT_W`. `stallCount` also counts cycles spent in `ERR`.

## Timing
- Reset values: state `RUN`, wait counter 0, `memTimeout` 0, `stallCount` 0, `redirectCount` 0.
- With all inputs 0 in reset, every combinational output is 0.
- Reset asserted mid-wait aborts the wait immediately. Asynchronous deassertion of `rst_n` is required to be synchronised externally.
- Stall, flush and forward outputs are combinational from the inputs and the registered state, and are valid in the same cycle.
- FSM and counter updates take effect at the next rising edge.
- A wait of N cycles (ready in cycle N, counting from the request cycle as 0) produces exactly N stalled cycles.
- `ERR` is entered after `TIMEOUT` unready cycles.

## Structure
- `pipeline_pkg` holds:
  - `fwd_sel_t` (`FWD_RF`, `FWD_WB`, `FWD_MEM`).
  - `hz_state_t` (`RUN`, `WAIT`, `ERR`).
- Sub-module `forwarding_unit` (combinational) is instantiated once and produces both forward selects.
- The FSM, priority logic and counters live in `hazard_ctrl`.

## Test plan
- **Back-to-back forwarding:** `add x5` followed by `sub` using x5 gives `forwardAE`=2'b10. One cycle later the WB match gives 2'b01. Writes to x0 always give 2'b00.
- **Load-use:** `lw x6` in EX with `rs2D`=6 gives one cycle of `stallF`=`stallD`=`flushE`=1, then all 0. `stallCount` advances by 1.
- **Redirect plus load-use:** `pcSrcE`=1 and loadUse in the same cycle give `flushD`=`flushE`=1 and `stallF`=0. `redirectCount` advances by 1.
- **Memory wait:** `dmemReqM`=1 with `dmemReadyM` low for 3 cycles gives 3 cycles of all stalls plus `flushW`. The FSM is back in `RUN` after the ready cycle. A `pcSrcE` asserted during the wait is serviced in the cycle after release.
- **Timeout:** `TIMEOUT`=4 and ready never asserted leads to `ERR` after 4 wait cycles, with `memTimeout`=1 and stalls held. Asserting `rst_n` low clears everything to reset values.
- **Counter wrap:** with `CNT_W`=4 and 17 redirects, `redirectCount` reads 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types for the pipeline hazard/forwarding logic
package pipeline_pkg;

   // EX operand source select
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Data-memory wait sequencer states
   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } hz_state_t;

   // MEM result is younger than WB, so it wins when both match
   function automatic fwd_sel_t fwd_pick(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         return FWD_MEM;
      end
      if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - EX-stage operand forwarding selects
module forwarding_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] rs1E,
   input  logic [4:0] rs2E,
   input  logic [4:0] rdM,
   input  logic       regWriteM,
   input  logic [4:0] rdW,
   input  logic       regWriteW,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE
);

   // Pick the newest in-flight producer for each EX source operand
   always_comb begin
      forwardAE = fwd_pick(rs1E, rdM, regWriteM, rdW, regWriteW);
      forwardBE = fwd_pick(rs2E, rdM, regWriteM, rdW, regWriteW);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with dmem wait watchdog
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [4:0]       rs1E,
   input  logic [4:0]       rs2E,
   input  logic [4:0]       rdE,
   input  logic             memReadE,
   input  logic             pcSrcE,
   input  logic [4:0]       rdM,
   input  logic             regWriteM,
   input  logic [4:0]       rdW,
   input  logic             regWriteW,
   input  logic             dmemReqM,
   input  logic             dmemReadyM,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             memTimeout,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] redirectCount
);

   // Wait counter only needs to reach TIMEOUT-1
   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   hz_state_t        state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

   logic mem_stall;
   logic load_use;
   logic redirect;
   logic any_stall;

   forwarding_unit u_fwd (
      .rs1E      (rs1E),
      .rs2E      (rs2E),
      .rdM       (rdM),
      .regWriteM (regWriteM),
      .rdW       (rdW),
      .regWriteW (regWriteW),
      .forwardAE (forwardAE),
      .forwardBE (forwardBE)
   );

   // Prioritised stall/flush decode: memory wait, then redirect, then load-use
   always_comb begin
      mem_stall = (dmemReqM && !dmemReadyM) || (state_q == ERR);
      load_use  = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      redirect  = 1'b0;
      if (mem_stall) begin
         // EX is frozen, so a pending redirect or load-use simply waits
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (pcSrcE) begin
         // The dependent ID instruction is squashed, so no load-use bubble
         flushD   = 1'b1;
         flushE   = 1'b1;
         redirect = 1'b1;
      end else if (load_use) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
      any_stall = stallF || stallD || stallE || stallM;
   end

   // Wait sequencer, sticky timeout and performance counters next-state
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      mem_timeout_d  = mem_timeout_q;
      stall_cnt_d    = stall_cnt_q + {{(CNT_W-1){1'b0}}, any_stall};
      redirect_cnt_d = redirect_cnt_q + {{(CNT_W-1){1'b0}}, redirect};
      unique case (state_q)
         RUN: begin
            if (dmemReqM && !dmemReadyM) begin
               state_d    = WAIT;
               wait_cnt_d = WCW'(1);
            end
         end
         WAIT: begin
            if (dmemReadyM) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d       = ERR;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         wait_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cnt_q    <= stall_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign memTimeout    = mem_timeout_q;
   assign stallCount    = stall_cnt_q;
   assign redirectCount = redirect_cnt_q;

endmodule
